// File: rtl/biquad_chain_tap_sat.sv
// -----------------------------------------------------------------------------
// biquad_chain_tap_sat
//
// Output stage for an NSTAGES-deep biquad cascade. It picks one cascade stage
// as the trigger-path source, requantises each lane from INBITS/INFRAC
// fixed point to an OUTBITS integer with saturation, and flags the lanes that
// clip. Clipped samples are counted and read out through a 4-phase snapshot
// handshake. All logic is in the aclk domain.
//
// Optional build macro: OUT_ROUND_EN
//   defined   : round half up (add 2^(INFRAC-1)) before the shift
//   undefined : truncate toward -inf
//
// Ports
//   aclk, aresetn  clock, asynchronous active-low reset
//   dat_i          NSTAGES*NSAMP samples; stage s lane i at [(s*NSAMP+i)*INBITS]
//   tap_sel_i      requested stage index, loaded on tap_update_i
//   tap_update_i   single-cycle load strobe (out-of-range requests ignored)
//   tap_o          active tap
//   dat_o          requantised samples, lane i at [i*OUTBITS]; latency 2
//   clip_o         per-lane clip flags, aligned with dat_o
//   snap_req_i     snapshot request (4-phase level)
//   snap_ack_o     snapshot acknowledge
//   clip_count_o   clipped-sample count latched at the last snapshot
// -----------------------------------------------------------------------------
module biquad_chain_tap_sat #(
  parameter int NSAMP    = 8,
  parameter int NSTAGES  = 2,
  parameter int INBITS   = 16,
  parameter int INFRAC   = 2,
  parameter int OUTBITS  = 12,
  parameter int CNTBITS  = 16,
  parameter int TSELBITS = 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NSTAGES*NSAMP*INBITS-1:0]   dat_i,
  input  logic [TSELBITS-1:0]               tap_sel_i,
  input  logic                              tap_update_i,
  output logic [TSELBITS-1:0]               tap_o,
  output logic [NSAMP*OUTBITS-1:0]          dat_o,
  output logic [NSAMP-1:0]                  clip_o,
  input  logic                              snap_req_i,
  output logic                              snap_ack_o,
  output logic [CNTBITS-1:0]                clip_count_o
);

  localparam int PCW = $clog2(NSAMP + 1);
  localparam int SW  = CNTBITS + PCW;

  // Rounding offset applied in INBITS+1 bits so that rounding up the most
  // positive sample cannot wrap negative; it saturates to max instead.
`ifdef OUT_ROUND_EN
  localparam logic [INBITS:0] RND = ((INBITS+1)'(1) << INFRAC) >> 1;
`else
  localparam logic [INBITS:0] RND = '0;
`endif

  localparam logic [OUTBITS-1:0] OMAX = {1'b0, {(OUTBITS-1){1'b1}}};
  localparam logic [OUTBITS-1:0] OMIN = {1'b1, {(OUTBITS-1){1'b0}}};
  localparam logic [SW-1:0]      CMAX = SW'({CNTBITS{1'b1}});

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  logic [TSELBITS-1:0]        r_tap;
  logic [NSAMP*INBITS-1:0]    w_sel;
  logic [NSAMP*INBITS-1:0]    r_sel;
  logic [NSAMP*OUTBITS-1:0]   w_dat_n;
  logic [NSAMP-1:0]           w_clip_n;
  logic [NSAMP*OUTBITS-1:0]   r_dat;
  logic [NSAMP-1:0]           r_clip;
  logic [PCW-1:0]             w_pop;
  logic [SW-1:0]              w_sum;
  logic [CNTBITS-1:0]         w_sat;
  logic [CNTBITS-1:0]         r_cnt;
  logic [CNTBITS-1:0]         r_snap;
  state_t                     r_state;
  state_t                     w_state_n;
  logic                       w_take;

  // Tap register: only in-range stage indices are accepted.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tap <= '0;
    end else if (tap_update_i && (int'(tap_sel_i) < NSTAGES)) begin
      r_tap <= tap_sel_i;
    end
  end

  // Stage mux driven by the registered tap, so a new tap takes effect the
  // cycle after the strobe and never mixes stages within one sample word.
  // NOTE: every combinational output gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    w_sel = '0;
    for (int s = 0; s < NSTAGES; s++) begin
      if (int'(r_tap) == s) begin
        w_sel = dat_i[s*NSAMP*INBITS +: NSAMP*INBITS];
      end
    end
  end

  // Requantise and saturate. The sample is sign-extended by one bit so the
  // optional rounding add cannot overflow; clipping is detected when the
  // bits above the kept OUTBITS-1 magnitude bits disagree with the sign.
  always_comb begin
    logic [INBITS:0]                 v_ext;
    logic [INBITS-INFRAC-OUTBITS+1:0] v_hi;
    w_dat_n  = '0;
    w_clip_n = '0;
    for (int i = 0; i < NSAMP; i++) begin
      v_ext = {r_sel[i*INBITS + INBITS - 1], r_sel[i*INBITS +: INBITS]} + RND;
      v_hi  = v_ext[INBITS : INFRAC + OUTBITS - 1];
      w_clip_n[i] = !((&v_hi) || (~|v_hi));
      w_dat_n[i*OUTBITS +: OUTBITS] = w_clip_n[i]
                                      ? (v_ext[INBITS] ? OMIN : OMAX)
                                      : v_ext[INFRAC +: OUTBITS];
    end
  end

  // Saturating accumulate of this cycle's clipped lanes.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NSAMP; i++) begin
      w_pop = w_pop + PCW'(w_clip_n[i]);
    end
    w_sum = SW'(r_cnt) + SW'(w_pop);
    w_sat = (w_sum > CMAX) ? {CNTBITS{1'b1}} : w_sum[CNTBITS-1:0];
  end

  // Snapshot FSM: a snapshot is taken only on the IDLE->ACK transition.
  always_comb begin
    w_state_n = r_state;
    w_take    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (snap_req_i) begin
          w_state_n = ST_ACK;
          w_take    = 1'b1;
        end
      end
      ST_ACK: begin
        if (!snap_req_i) begin
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Clips seen in the snapshot cycle land in the snapshot, and the running
  // count restarts from zero, so nothing is lost or counted twice.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sel   <= '0;
      r_dat   <= '0;
      r_clip  <= '0;
      r_cnt   <= '0;
      r_snap  <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_sel   <= w_sel;
      r_dat   <= w_dat_n;
      r_clip  <= w_clip_n;
      r_state <= w_state_n;
      if (w_take) begin
        r_snap <= w_sat;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= w_sat;
      end
    end
  end

  assign tap_o        = r_tap;
  assign dat_o        = r_dat;
  assign clip_o       = r_clip;
  assign snap_ack_o   = (r_state == ST_ACK);
  assign clip_count_o = r_snap;

endmodule

// File: tb/tb_biquad_chain_tap_sat.sv
// -----------------------------------------------------------------------------
// tb_biquad_chain_tap_sat
//
// Directed bench for biquad_chain_tap_sat. A main instance (CNTBITS=16) and a
// narrow-counter instance (CNTBITS=4) share all inputs. A behavioural model
// computes expected outputs from arithmetic on the input samples; a compare
// process checks every cycle, and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_biquad_chain_tap_sat;

  localparam int NSAMP    = 8;
  localparam int NSTAGES  = 2;
  localparam int INBITS   = 16;
  localparam int INFRAC   = 2;
  localparam int OUTBITS  = 12;
  localparam int TSELBITS = 2;
  localparam longint OMAXV = (longint'(1) << (OUTBITS-1)) - 1;
  localparam longint OMINV = -(longint'(1) << (OUTBITS-1));

  logic                            aclk = 1'b0;
  logic                            aresetn = 1'b0;
  logic [NSTAGES*NSAMP*INBITS-1:0] dat_i = '0;
  logic [TSELBITS-1:0]             tap_sel_i = '0;
  logic                            tap_update_i = 1'b0;
  logic                            snap_req_i = 1'b0;
  logic [TSELBITS-1:0]             tap_o, tap4_o;
  logic [NSAMP*OUTBITS-1:0]        dat_o, dat4_o;
  logic [NSAMP-1:0]                clip_o, clip4_o;
  logic                            snap_ack_o, snap_ack4_o;
  logic [15:0]                     clip_count_o;
  logic [3:0]                      clip_count4_o;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  biquad_chain_tap_sat #(
    .NSAMP(NSAMP), .NSTAGES(NSTAGES), .INBITS(INBITS), .INFRAC(INFRAC),
    .OUTBITS(OUTBITS), .CNTBITS(16), .TSELBITS(TSELBITS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .dat_i(dat_i), .tap_sel_i(tap_sel_i),
    .tap_update_i(tap_update_i), .tap_o(tap_o), .dat_o(dat_o), .clip_o(clip_o),
    .snap_req_i(snap_req_i), .snap_ack_o(snap_ack_o), .clip_count_o(clip_count_o)
  );

  biquad_chain_tap_sat #(
    .NSAMP(NSAMP), .NSTAGES(NSTAGES), .INBITS(INBITS), .INFRAC(INFRAC),
    .OUTBITS(OUTBITS), .CNTBITS(4), .TSELBITS(TSELBITS)
  ) dut4 (
    .aclk(aclk), .aresetn(aresetn), .dat_i(dat_i), .tap_sel_i(tap_sel_i),
    .tap_update_i(tap_update_i), .tap_o(tap4_o), .dat_o(dat4_o), .clip_o(clip4_o),
    .snap_req_i(snap_req_i), .snap_ack_o(snap_ack4_o), .clip_count_o(clip_count4_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int                        m_tap = 0;
  logic [NSAMP*OUTBITS-1:0]  m_d1_dat = '0, m_dat = '0;
  logic [NSAMP-1:0]          m_d1_clip = '0, m_clip = '0;
  longint                    m_cnt = 0, m_cnt4 = 0, m_cc = 0, m_cc4 = 0;
  bit                        m_ack = 1'b0;

  function automatic void quant(input logic [INBITS-1:0] s,
                                output logic [OUTBITS-1:0] q, output logic c);
    longint v;
    v = longint'($signed(s));
`ifdef OUT_ROUND_EN
    v = v + ((longint'(1) << INFRAC) >> 1);
`endif
    v = v >>> INFRAC;
    c = 1'b1;
    if (v > OMAXV)      q = OUTBITS'(OMAXV);
    else if (v < OMINV) q = OUTBITS'(OMINV);
    else begin
      q = v[OUTBITS-1:0];
      c = 1'b0;
    end
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int bits);
    longint lim;
    lim = (longint'(1) << bits) - 1;
    return (a + b > lim) ? lim : a + b;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tap = 0; m_d1_dat = '0; m_dat = '0; m_d1_clip = '0; m_clip = '0;
      m_cnt = 0; m_cnt4 = 0; m_cc = 0; m_cc4 = 0; m_ack = 1'b0;
    end else begin
      longint pop;
      logic [OUTBITS-1:0] q;
      logic c;
      // Output visible after this edge is what was selected one edge ago.
      m_dat  = m_d1_dat;
      m_clip = m_d1_clip;
      for (int i = 0; i < NSAMP; i++) begin
        quant(dat_i[(m_tap*NSAMP + i)*INBITS +: INBITS], q, c);
        m_d1_dat[i*OUTBITS +: OUTBITS] = q;
        m_d1_clip[i] = c;
      end
      pop = longint'($countones(m_clip));
      if (!m_ack && snap_req_i) begin
        m_cc  = sat_add(m_cnt, pop, 16);
        m_cc4 = sat_add(m_cnt4, pop, 4);
        m_cnt = 0; m_cnt4 = 0; m_ack = 1'b1;
      end else begin
        m_cnt  = sat_add(m_cnt, pop, 16);
        m_cnt4 = sat_add(m_cnt4, pop, 4);
        if (m_ack && !snap_req_i) m_ack = 1'b0;
      end
      if (tap_update_i && int'(tap_sel_i) < NSTAGES) m_tap = int'(tap_sel_i);
    end
  end

  // Per-cycle comparison, on the falling edge away from register updates.
  always @(negedge aclk) begin
    if (run_cmp) begin
      check("cyc_tap",    128'(tap_o),         128'(m_tap));
      check("cyc_dat",    128'(dat_o),         128'(m_dat));
      check("cyc_clip",   128'(clip_o),        128'(m_clip));
      check("cyc_ack",    128'(snap_ack_o),    128'(m_ack));
      check("cyc_cnt",    128'(clip_count_o),  128'(m_cc));
      check("cyc_ack4",   128'(snap_ack4_o),   128'(m_ack));
      check("cyc_cnt4",   128'(clip_count4_o), 128'(m_cc4));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge aclk);
      #1;
    end
  endtask

  task automatic set_lane(input int s, input int i, input logic [INBITS-1:0] v);
    dat_i[(s*NSAMP + i)*INBITS +: INBITS] = v;
  endtask

  function automatic logic [OUTBITS-1:0] lane_out(input int i);
    return dat_o[i*OUTBITS +: OUTBITS];
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
  endtask

  initial begin
    tick(2);
    run_cmp = 1'b1;
    // Reset state
    check("rst_tap",  128'(tap_o), 128'(0));
    check("rst_dat",  128'(dat_o), 128'(0));
    check("rst_clip", 128'(clip_o), 128'(0));
    check("rst_ack",  128'(snap_ack_o), 128'(0));
    check("rst_cnt",  128'(clip_count_o), 128'(0));
    aresetn = 1'b1;

    // Requantise/saturate corner values on stage 0
    set_lane(0, 0, 16'h0FFC);  // 1023.0  -> 3FF
    set_lane(0, 1, 16'hFFFF);  // -0.25   -> -1
    set_lane(0, 2, 16'h2000);  // 2048.0  -> 7FF clip
    set_lane(0, 3, 16'h7FFC);  // max     -> 7FF clip
    set_lane(0, 4, 16'hE000);  // -2048.0 -> 800
    set_lane(0, 5, 16'h8000);  // min     -> 800 clip
    set_lane(0, 6, 16'h1FFC);  // 2047.0  -> 7FF
    set_lane(0, 7, 16'hDFFC);  // -2049.0 -> 800 clip
    tick(2);
    check("q_lane0", 128'(lane_out(0)), 128'(12'h3FF));
    check("q_lane1", 128'(lane_out(1)), 128'(12'hFFF));
    check("q_lane2", 128'(lane_out(2)), 128'(12'h7FF));
    check("q_lane3", 128'(lane_out(3)), 128'(12'h7FF));
    check("q_lane4", 128'(lane_out(4)), 128'(12'h800));
    check("q_lane5", 128'(lane_out(5)), 128'(12'h800));
    check("q_lane6", 128'(lane_out(6)), 128'(12'h7FF));
    check("q_lane7", 128'(lane_out(7)), 128'(12'h800));
    check("q_clip",  128'(clip_o),      128'(8'hAC));

    // Tap switch: stage1 = 1.0 in every lane, stage0 = 0
    dat_i = '0;
    for (int i = 0; i < NSAMP; i++) set_lane(1, i, 16'h0004);
    tick(2);
    tap_sel_i = 2'd1;
    tap_update_i = 1'b1;
    tick();
    tap_update_i = 1'b0;
    check("tap_loaded", 128'(tap_o), 128'(1));
    check("tap_old0",   128'(lane_out(0)), 128'(0));
    tick();
    check("tap_old1",   128'(lane_out(0)), 128'(0));
    tick();
    check("tap_new",    128'(dat_o), 128'({NSAMP{12'h001}}));
    tap_sel_i = 2'd2;
    tap_update_i = 1'b1;
    tick();
    check("tap_oob2", 128'(tap_o), 128'(1));
    tap_sel_i = 2'd3;
    tick();
    tap_update_i = 1'b0;
    check("tap_oob3", 128'(tap_o), 128'(1));
    tick();

    // 4 lanes clipping for 10 cycles, snapshot in the 10th
    do_reset();
    dat_i = '0;
    for (int i = 0; i < 4; i++) set_lane(0, i, 16'h7FFC);
    tick(10);
    dat_i = '0;
    snap_req_i = 1'b1;
    tick();
    check("snap40",      128'(clip_count_o),  128'(40));
    check("snap40_ack",  128'(snap_ack_o),    128'(1));
    check("snap40_sat4", 128'(clip_count4_o), 128'(15));
    tick();
    snap_req_i = 1'b0;
    tick();
    check("ack_drop", 128'(snap_ack_o), 128'(0));
    snap_req_i = 1'b1;
    tick();
    check("snap_zero", 128'(clip_count_o), 128'(0));
    snap_req_i = 1'b0;
    tick(2);

    // 8 lanes clipping for 3 cycles, snapshot
    do_reset();
    for (int i = 0; i < NSAMP; i++) set_lane(0, i, 16'h7FFC);
    tick(3);
    dat_i = '0;
    set_lane(0, 0, 16'h0FFC);
    snap_req_i = 1'b1;
    tick();
    check("snap24",     128'(clip_count_o),  128'(24));
    check("snap_sat15", 128'(clip_count4_o), 128'(15));
    tick(2);
    check("pre_rst_dat", 128'(lane_out(0)), 128'(12'h3FF));

    // Reset in the middle of the handshake clears asynchronously
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_ack", 128'(snap_ack_o),   128'(0));
    check("arst_cnt", 128'(clip_count_o), 128'(0));
    check("arst_dat", 128'(dat_o),        128'(0));
    snap_req_i = 1'b0;
    tick(2);
    aresetn = 1'b1;

    // Rounding-sensitive sample
    dat_i = '0;
    set_lane(0, 0, 16'h0FFE);
    set_lane(0, 1, 16'h7FFE);
    tick(2);
`ifdef OUT_ROUND_EN
    check("round_0ffe", 128'(lane_out(0)), 128'(12'h400));
`else
    check("round_0ffe", 128'(lane_out(0)), 128'(12'h3FF));
`endif
    check("round_7ffe",  128'(lane_out(1)), 128'(12'h7FF));
    check("round_clip",  128'(clip_o),      128'(8'h02));
    tick(2);

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/biquad_chain_tap_sat.md
Name: biquad_chain_tap_sat

Overview:
Parametrised output stage for an NSTAGES-deep biquad cascade, generalising the fixed two-stage, 8-sample, 16→12-bit clip path.
- Selects which cascade stage output drives the trigger path (runtime tap select, applied on an update strobe).
- Requantises INBITS/INFRAC samples to OUTBITS integers with saturation.
- Flags clips per lane and accumulates a clipped-sample count, read out through a 4-phase snapshot handshake.
- Sits between the biquad cascade and the trigger/beamformer input, in the aclk domain.

Parameters:
NSAMP, 8, samples per clock (lanes)
NSTAGES, 2, number of cascade stage outputs presented on dat_i
INBITS, 16, input sample width (signed two's complement)
INFRAC, 2, fractional bits in input samples (0 ≤ INFRAC < INBITS)
OUTBITS, 12, output sample width (signed integer, OUTBITS ≤ INBITS-INFRAC)
CNTBITS, 16, clip counter width
TSELBITS, 1, tap select width (≥ clog2(NSTAGES), min 1)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
dat_i  in  NSTAGES*NSAMP*INBITS  stage s, lane i at [(s*NSAMP+i)*INBITS +: INBITS]
tap_sel_i  in  TSELBITS  requested stage index
tap_update_i  in  1  single-cycle strobe: load tap_sel_i
tap_o  out  TSELBITS  active tap
dat_o  out  NSAMP*OUTBITS  requantised, saturated samples, lane i at [i*OUTBITS +: OUTBITS]
clip_o  out  NSAMP  per-lane clip flag, aligned with dat_o
snap_req_i  in  1  snapshot request (4-phase level)
snap_ack_o  out  1  snapshot acknowledge
clip_count_o  out  CNTBITS  clipped-sample count latched at last snapshot

Behaviour:
- Reset (aresetn low, async): tap_o=0; dat_o=0; clip_o=0; snap_ack_o=0; clip_count_o=0; internal counter=0; pipeline regs=0.
- Tap register:
  - On tap_update_i, load tap_sel_i if tap_sel_i < NSTAGES.
  - Out-of-range values are ignored; tap_o holds.
  - New tap affects the mux in the cycle after the strobe.
- Pipeline, latency 2 cycles:
  - Cycle 1: register the selected stage's NSAMP lanes.
  - Cycle 2: requantise, saturate, register dat_o and clip_o.
  - On a tap change, dat_o shows the old tap for exactly 2 more cycles, then the new tap. No bubble, no mixed-tap cycle.
- Requantise: integer part = sample >>> INFRAC (arithmetic shift, truncation toward −inf).
- Saturate:
  - If integer part > 2^(OUTBITS-1)-1: output max, clip bit=1.
  - If integer part < −2^(OUTBITS-1): output min, clip bit=1.
  - Otherwise: low OUTBITS bits, clip bit=0.
  - Detection: bits [INBITS-1 : INFRAC+OUTBITS-1] are not all equal.
- Clip counter (internal):
  - Each cycle, add popcount(clip_o next value).
  - Saturates at 2^CNTBITS−1; never wraps.
- Snapshot FSM, states IDLE and ACK:
  - IDLE→ACK when snap_req_i=1. In that cycle: clip_count_o ← counter + this cycle's popcount (saturated); counter ← 0; snap_ack_o ← 1.
  - Clips occurring in the transition cycle go into the snapshot, not the new count. Nothing is lost or double counted.
  - ACK: hold snap_ack_o=1; counter accumulates normally.
  - ACK→IDLE when snap_req_i=0; snap_ack_o ← 0.
  - A new snapshot requires a full req low/high cycle.
- Reset mid-handshake: FSM returns to IDLE, ack drops asynchronously, count and snapshot clear.

Optional Feature:
Macro OUT_ROUND_EN.
- Defined: round half up before the shift. Add 2^(INFRAC-1) to the sample in INBITS+1 bits, then shift and saturate, so a positive overflow from rounding clips to max. No effect when INFRAC=0. Latency unchanged.
- Undefined: truncation as above.

Test Plan:
- Defaults, tap 0, lane 0 = 16'h0FFC (1023.0) → dat_o lane0 = 12'h3FF, clip_o = 0, 2 cycles after input.
- Lane 3 = 16'h7FFC → 12'h7FF, clip_o[3]=1. Lane 5 = 16'h8000 → 12'h800, clip_o[5]=1. Lane 6 = 16'h1FFC (2047.0) → 12'h7FF, clip_o[6]=0.
- Stage1 lanes = 16'h0004, stage0 = 0, pulse tap_update_i with tap_sel_i=1 → dat_o = 1 from the 3rd cycle after the strobe. Then tap_sel_i=2 with NSTAGES=2 → tap_o stays 1.
- 4 lanes clipping for 10 cycles, raise snap_req_i in the 10th → clip_count_o = 40, snap_ack_o=1 next cycle. Drop req → ack=0. Re-request after 0 clips → 0.
- CNTBITS=4, 8 lanes clipping for 3 cycles, snapshot → 15 (saturated).
- Assert aresetn low while snap_ack_o=1 → ack, clip_count_o and dat_o go to 0 immediately. With OUT_ROUND_EN, input 16'h0FFE → 12'h400 (unrounded build → 12'h3FF).
